encoder_scanner: RTL

ENCODER_SCANNER -- requirements
Module: encoder_scanner

---
 rtl/encoder_pkg.sv | 19 +
 rtl/encoder_scanner_sync2.sv | 24 ++
 rtl/encoder_scanner.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared decoder definitions for encoder_scanner.
// Holds the four quadrature transition codes, written as {sa,oa,sb,ob},
// and the step type that the decoder produces.
package encoder_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_t;

  // A rises while B is low, or A falls while B is high
  localparam logic [3:0] CODE_UP_A   = 4'b1000;
  localparam logic [3:0] CODE_UP_B   = 4'b0111;
  // B rises while A is low, or B falls while A is high
  localparam logic [3:0] CODE_DOWN_A = 4'b0010;
  localparam logic [3:0] CODE_DOWN_B = 4'b1101;

endpackage

// File: rtl/encoder_scanner_sync2.sv
// sync2: two-flop synchronizer for a bus of independent asynchronous bits.
// Ports: clk, reset (async, active-high), d (async input), q (synchronized).
module sync2 #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/encoder_scanner.sv
// encoder_scanner: time-multiplexed quadrature decoder for NUM_CH encoders.
// One shared decoder visits channel ptr per cycle while scan_en is high and
// steps that channel's value by INCREMENT; the host may preload any channel.
// Ports:
//   clk, reset           clock, async active-high reset
//   scan_en              advance the scan pointer one channel per cycle
//   a, b                 raw encoder phases, one bit per channel
//   load_valid/ch/value  single-cycle preload of one channel value
//   values               all channel values, channel i at [i*WIDTH +: WIDTH]
//   upd_valid/ch/dir     pulse reporting a stepped channel and its direction
// Build option: define ENCODER_SCANNER_SATURATE_EN to clamp values at
// 0 and 2^WIDTH-1 instead of wrapping.
module encoder_scanner
  import encoder_pkg::*;
#(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned INCREMENT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      scan_en,
  input  logic [NUM_CH-1:0]         a,
  input  logic [NUM_CH-1:0]         b,
  input  logic                      load_valid,
  input  logic [$clog2(NUM_CH)-1:0] load_ch,
  input  logic [WIDTH-1:0]          load_value,
  output logic [NUM_CH*WIDTH-1:0]   values,
  output logic                      upd_valid,
  output logic [$clog2(NUM_CH)-1:0] upd_ch,
  output logic                      upd_dir
);

  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam int unsigned VW   = WIDTH + 1;

  logic [2*NUM_CH-1:0] s_ab;
  logic [NUM_CH-1:0]   sa, sb;
  logic [NUM_CH-1:0]   oa, ob;
  logic [CH_W-1:0]     ptr;

  logic                cur_sa, cur_sb, cur_oa, cur_ob;
  logic [3:0]          code;
  step_t               step;
  logic [WIDTH-1:0]    cur_val, up_val, dn_val, new_val;
  logic                load_hit, load_same, do_step;
`ifdef ENCODER_SCANNER_SATURATE_EN
  logic [VW-1:0]       sum;
`endif

  sync2 #(.W(2*NUM_CH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({a, b}),
    .q     (s_ab)
  );

  assign sa = s_ab[2*NUM_CH-1:NUM_CH];
  assign sb = s_ab[NUM_CH-1:0];

  // Shared decoder: select the visited channel, classify its transition,
  // and form the stepped value.
  always_comb begin
    cur_sa  = 1'b0;
    cur_sb  = 1'b0;
    cur_oa  = 1'b0;
    cur_ob  = 1'b0;
    cur_val = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ptr == CH_W'(i)) begin
        cur_sa  = sa[i];
        cur_sb  = sb[i];
        cur_oa  = oa[i];
        cur_ob  = ob[i];
        cur_val = values[i*WIDTH +: WIDTH];
      end
    end

    code = {cur_sa, cur_oa, cur_sb, cur_ob};
    step = STEP_NONE;
    if (scan_en) begin
      case (code)
        CODE_UP_A, CODE_UP_B:     step = STEP_UP;
        CODE_DOWN_A, CODE_DOWN_B: step = STEP_DOWN;
        default:                  step = STEP_NONE;
      endcase
    end

`ifdef ENCODER_SCANNER_SATURATE_EN
    sum    = VW'(cur_val) + VW'(INCREMENT);
    up_val = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    dn_val = (VW'(INCREMENT) > VW'(cur_val)) ? '0 : cur_val - WIDTH'(INCREMENT);
`else
    up_val = cur_val + WIDTH'(INCREMENT);
    dn_val = cur_val - WIDTH'(INCREMENT);
`endif
    new_val = (step == STEP_UP) ? up_val : dn_val;

    // A load to the visited channel overrides the step that cycle.
    load_hit  = load_valid && (32'(load_ch) < NUM_CH);
    load_same = load_hit && (load_ch == ptr);
`ifdef ENCODER_SCANNER_SATURATE_EN
    do_step   = (step != STEP_NONE) && (new_val != cur_val) && !load_same;
`else
    do_step   = (step != STEP_NONE) && !load_same;
`endif
  end

  // Scan pointer, per-channel phase history, values and update report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      oa        <= '0;
      ob        <= '0;
      values    <= '0;
      upd_valid <= 1'b0;
      upd_ch    <= '0;
      upd_dir   <= 1'b0;
    end else begin
      upd_valid <= do_step;
      upd_ch    <= ptr;
      upd_dir   <= (step == STEP_UP);

      if (scan_en) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (ptr == CH_W'(i)) begin
            oa[i] <= cur_sa;
            ob[i] <= cur_sb;
          end
        end
        ptr <= (ptr == CH_W'(NUM_CH - 1)) ? '0 : ptr + CH_W'(1);
      end

      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (load_hit && (load_ch == CH_W'(i))) begin
          values[i*WIDTH +: WIDTH] <= load_value;
        end else if (do_step && (ptr == CH_W'(i))) begin
          values[i*WIDTH +: WIDTH] <= new_val;
        end
      end
    end
  end

endmodule
